pht_sat_table: RTL and testbench

//  Parametrised pattern history table of CTR_WIDTH-bit saturating counters for the branch predictor front end.

---
 rtl/pht_sat_table.sv | 118 +++++++++++
 tb/tb_pht_sat_table.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pht_sat_table.sv
// Pattern history table of saturating counters: registered write-first read port, strength output and init/flush sweep.
// Optional statistics counters are built in when PHT_STATS_EN is defined.
module pht_sat_table #(
    parameter int unsigned INDEX_WIDTH = 12,
    parameter int unsigned CTR_WIDTH   = 2,
    parameter int unsigned INIT_VALUE  = 2**(CTR_WIDTH-1)-1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    output logic                   ready_o,
    input  logic                   rd_en_i,
    input  logic [INDEX_WIDTH-1:0] rd_index_i,
    output logic                   rd_valid_o,
    output logic                   br_prediction_o,
    output logic                   br_strong_o,
    input  logic                   update_en_i,
    input  logic [INDEX_WIDTH-1:0] update_index_i,
`ifdef PHT_STATS_EN
    output logic [31:0]            stat_updates_o,
    output logic [31:0]            stat_mispred_o,
`endif
    input  logic                   br_taken_i
);

    localparam int unsigned TABLE_SIZE = 2**INDEX_WIDTH;
    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
    localparam logic [CTR_WIDTH-1:0] INIT_CTR = CTR_WIDTH'(INIT_VALUE);

    typedef enum logic {ST_INIT, ST_READY} state_e;

    state_e                 state, state_nxt;
    logic [INDEX_WIDTH-1:0] ptr;
    logic                   sweep_we;
    logic                   upd_acc;
    logic                   rd_acc;
    logic [CTR_WIDTH-1:0]   upd_old;
    logic [CTR_WIDTH-1:0]   upd_new;
    logic [CTR_WIDTH-1:0]   rd_ctr;

    logic [CTR_WIDTH-1:0]   table_mem [TABLE_SIZE];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ST_INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:  if (!flush_i && ptr == '1) state_nxt = ST_READY;
            ST_READY: if (flush_i) state_nxt = ST_INIT;
            default:  state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        ready_o  = (state == ST_READY);
        sweep_we = (state == ST_INIT) && !flush_i;
    end

    // Pointer is held at zero outside the sweep so a flush always restarts from entry 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                          ptr <= '0;
        else if (flush_i || !sweep_we)      ptr <= '0;
        else                                ptr <= ptr + INDEX_WIDTH'(1);
    end

    always_comb begin
        upd_acc = ready_o && update_en_i && !flush_i;
        rd_acc  = ready_o && rd_en_i && !flush_i;
        upd_old = table_mem[update_index_i];
        upd_new = upd_old;
        if (br_taken_i && upd_old != CTR_MAX)       upd_new = upd_old + CTR_WIDTH'(1);
        else if (!br_taken_i && upd_old != '0)      upd_new = upd_old - CTR_WIDTH'(1);
        rd_ctr = (upd_acc && rd_index_i == update_index_i) ? upd_new : table_mem[rd_index_i];
    end

    always_ff @(posedge clk_i) begin
        if (sweep_we)     table_mem[ptr]            <= INIT_CTR;
        else if (upd_acc) table_mem[update_index_i] <= upd_new;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_valid_o      <= 1'b0;
            br_prediction_o <= 1'b0;
            br_strong_o     <= 1'b0;
        end else if (rd_acc) begin
            rd_valid_o      <= 1'b1;
            br_prediction_o <= rd_ctr[CTR_WIDTH-1];
            br_strong_o     <= (rd_ctr == '0) || (rd_ctr == CTR_MAX);
        end else if (rd_en_i) begin
            rd_valid_o      <= 1'b0;
            br_prediction_o <= 1'b0;
            br_strong_o     <= 1'b0;
        end else begin
            rd_valid_o      <= 1'b0;
        end
    end

`ifdef PHT_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_updates_o <= '0;
            stat_mispred_o <= '0;
        end else if (flush_i) begin
            stat_updates_o <= '0;
            stat_mispred_o <= '0;
        end else if (upd_acc) begin
            if (stat_updates_o != '1) stat_updates_o <= stat_updates_o + 32'd1;
            if (upd_old[CTR_WIDTH-1] != br_taken_i && stat_mispred_o != '1)
                stat_mispred_o <= stat_mispred_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pht_sat_table.sv
// Directed bench for pht_sat_table: a 2-bit/16-entry table and a 3-bit/16-entry table.
module tb_pht_sat_table;

    logic       clk_i = 1'b0;
    logic       rst_i, flush_i, rd_en_i, update_en_i, br_taken_i;
    logic [3:0] rd_index_i, update_index_i;
    logic       ready_o, rd_valid_o, br_prediction_o, br_strong_o;

    logic       rst2, flush2, rd_en2, upd_en2, taken2;
    logic [3:0] rd_idx2, upd_idx2;
    logic       ready2, rd_valid2, pred2, strong2;
`ifdef PHT_STATS_EN
    logic [31:0] stat_upd1, stat_mis1, stat_upd2, stat_mis2;
`endif

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned cnt;

    always #5 clk_i = ~clk_i;

    pht_sat_table #(.INDEX_WIDTH(4), .CTR_WIDTH(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .ready_o(ready_o),
        .rd_en_i(rd_en_i), .rd_index_i(rd_index_i), .rd_valid_o(rd_valid_o),
        .br_prediction_o(br_prediction_o), .br_strong_o(br_strong_o),
        .update_en_i(update_en_i), .update_index_i(update_index_i),
`ifdef PHT_STATS_EN
        .stat_updates_o(stat_upd1), .stat_mispred_o(stat_mis1),
`endif
        .br_taken_i(br_taken_i)
    );

    pht_sat_table #(.INDEX_WIDTH(4), .CTR_WIDTH(3)) dut3 (
        .clk_i(clk_i), .rst_i(rst2), .flush_i(flush2), .ready_o(ready2),
        .rd_en_i(rd_en2), .rd_index_i(rd_idx2), .rd_valid_o(rd_valid2),
        .br_prediction_o(pred2), .br_strong_o(strong2),
        .update_en_i(upd_en2), .update_index_i(upd_idx2),
`ifdef PHT_STATS_EN
        .stat_updates_o(stat_upd2), .stat_mispred_o(stat_mis2),
`endif
        .br_taken_i(taken2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic upd(input logic [3:0] idx, input logic taken);
        update_en_i = 1'b1; update_index_i = idx; br_taken_i = taken;
        tick();
        update_en_i = 1'b0;
    endtask

    task automatic rd(input logic [3:0] idx);
        rd_en_i = 1'b1; rd_index_i = idx;
        tick();
        rd_en_i = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int unsigned exp_cycles);
        cnt = 0;
        while (!ready_o && cnt < 100) begin
            tick();
            cnt++;
        end
        check(tag, cnt, exp_cycles);
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; rd_en_i = 1'b0; update_en_i = 1'b0;
        br_taken_i = 1'b0; rd_index_i = '0; update_index_i = '0;
        rst2 = 1'b1; flush2 = 1'b0; rd_en2 = 1'b0; upd_en2 = 1'b0;
        taken2 = 1'b0; rd_idx2 = '0; upd_idx2 = '0;
        tick(); tick();
        check("rst_ready", ready_o, 0);
        check("rst_valid", rd_valid_o, 0);
        check("rst_pred",  br_prediction_o, 0);
        check("rst_strong", br_strong_o, 0);
        rst_i = 1'b0; rst2 = 1'b0;
        wait_ready("init_sweep_len", 16);

        // Every entry holds INIT_VALUE 1: not taken, weak
        for (int i = 0; i < 16; i++) begin
            rd(4'(i));
            check($sformatf("init_valid%0d", i), rd_valid_o, 1);
            check($sformatf("init_ps%0d", i), {br_prediction_o, br_strong_o}, 2'b00);
        end

        // Saturation up and down on idx 5
        repeat (3) upd(4'd5, 1'b1);
        rd(4'd5);
        check("sat_up", {br_prediction_o, br_strong_o}, 2'b11);
        upd(4'd5, 1'b0);
        rd(4'd5);
        check("down_to2", {br_prediction_o, br_strong_o}, 2'b10);
        repeat (3) upd(4'd5, 1'b0);
        rd(4'd5);
        check("sat_down", {br_prediction_o, br_strong_o}, 2'b01);
        tick();
        check("idle_valid", rd_valid_o, 0);
        check("idle_hold", {br_prediction_o, br_strong_o}, 2'b01);

        // Write-first bypass on idx 3, then unrelated read during an update
        update_en_i = 1'b1; update_index_i = 4'd3; br_taken_i = 1'b1;
        rd_en_i = 1'b1; rd_index_i = 4'd3;
        tick();
        check("bypass_valid", rd_valid_o, 1);
        check("bypass_ps", {br_prediction_o, br_strong_o}, 2'b10);
        rd_index_i = 4'd4;
        tick();
        update_en_i = 1'b0; rd_en_i = 1'b0;
        check("nobypass_ps", {br_prediction_o, br_strong_o}, 2'b00);
        rd(4'd3);
        check("after_bypass", {br_prediction_o, br_strong_o}, 2'b11);

        // Flush wins over concurrent update and read; sweep-time accesses ignored
        repeat (2) upd(4'd7, 1'b1);
        rd(4'd7);
        check("idx7_sat", {br_prediction_o, br_strong_o}, 2'b11);
        flush_i = 1'b1; update_en_i = 1'b1; update_index_i = 4'd7; br_taken_i = 1'b0;
        rd_en_i = 1'b1; rd_index_i = 4'd7;
        tick();
        flush_i = 1'b0; update_en_i = 1'b0; rd_en_i = 1'b0;
        check("flush_valid", rd_valid_o, 0);
        check("flush_ready", ready_o, 0);
        cnt = 0;
        while (!ready_o && cnt < 100) begin
            if (cnt == 15) begin
                update_en_i = 1'b1; update_index_i = 4'd2; br_taken_i = 1'b1;
                rd_en_i = 1'b1; rd_index_i = 4'd2;
            end
            tick();
            cnt++;
            if (cnt == 16) begin
                update_en_i = 1'b0; rd_en_i = 1'b0;
                check("sweep_rd_valid", rd_valid_o, 0);
                check("sweep_rd_pred", br_prediction_o, 0);
            end
        end
        check("flush_sweep_len", cnt, 16);
        rd(4'd2);
        check("sweep_upd_ignored", {br_prediction_o, br_strong_o}, 2'b00);
        rd(4'd7);
        check("idx7_reinit", {br_prediction_o, br_strong_o}, 2'b00);

        // Flush during the sweep restarts it
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        repeat (5) tick();
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        wait_ready("flush_restart_len", 16);

        // Asynchronous reset mid-sweep
        repeat (2) upd(4'd9, 1'b1);
        rd(4'd9);
        check("idx9_sat", {rd_valid_o, br_prediction_o, br_strong_o}, 3'b111);
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        repeat (8) tick();
        check("hold_midsweep", {br_prediction_o, br_strong_o}, 2'b11);
        #2 rst_i = 1'b1;
        #1;
        check("async_rst_outs", {ready_o, rd_valid_o, br_prediction_o, br_strong_o}, 4'b0000);
        tick(); tick();
        rst_i = 1'b0;
        wait_ready("rst_sweep_len", 16);

        // 3-bit table: INIT 3, five taken updates saturate at 7
        repeat (5) begin
            upd_en2 = 1'b1; upd_idx2 = 4'd0; taken2 = 1'b1;
            tick();
        end
        upd_en2 = 1'b0;
        rd_en2 = 1'b1; rd_idx2 = 4'd0;
        tick();
        rd_en2 = 1'b0;
        check("w3_ready", ready2, 1);
        check("w3_ps", {rd_valid2, pred2, strong2}, 3'b111);
        rd_en2 = 1'b1; rd_idx2 = 4'd1;
        tick();
        rd_en2 = 1'b0;
        check("w3_init_ps", {pred2, strong2}, 2'b00);
`ifdef PHT_STATS_EN
        check("stat_updates", stat_upd2, 5);
        check("stat_mispred", stat_mis2, 1);
        check("stat1_cleared", stat_upd1, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
